// File: rtl/sample_mavg_filter.sv
// Moving-average filter over a 2^DEPTH_LOG2 sample window of 13-bit signed data.
// Defining SAMPLE_MAVG_PEAK_EN adds a peak tracker (peak_clr in, peak_data out).
module sample_mavg_filter #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_filter,
  input  logic               sample_valid,
  input  logic signed [12:0] sample_data,
`ifdef SAMPLE_MAVG_PEAK_EN
  input  logic               peak_clr,
  output logic signed [12:0] peak_data,
`endif
  output logic signed [12:0] filt_data,
  output logic               filt_valid,
  output logic               filt_ready
);

  localparam int N  = 1 << DEPTH_LOG2;
  localparam int SW = 13 + DEPTH_LOG2;
  localparam int FW = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                  state;
  logic signed [12:0]      win_mem [N];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [FW-1:0]           fill_cnt;
  logic signed [SW-1:0]    sum;
  logic signed [SW-1:0]    sum_nxt;
  logic signed [SW-1:0]    samp_ext;
  logic signed [SW-1:0]    old_ext;
  logic signed [12:0]      avg_nxt;
  logic                    accept;
  logic                    fill_done;
  logic                    out_fire;

  always_comb begin
    accept    = sample_valid && en_filter && (state != IDLE);
    fill_done = (fill_cnt == FW'(N - 1));
    out_fire  = accept && ((state == RUN) || ((state == FILL) && fill_done));
    samp_ext  = {{DEPTH_LOG2{sample_data[12]}}, sample_data};
    // The oldest sample is only subtracted once the window is full.
    old_ext   = (state == RUN) ? {{DEPTH_LOG2{win_mem[wr_ptr][12]}}, win_mem[wr_ptr]} : '0;
    sum_nxt   = sum + samp_ext - old_ext;
    avg_nxt   = 13'(sum_nxt >>> DEPTH_LOG2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sum        <= '0;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      filt_data  <= '0;
      filt_valid <= 1'b0;
      filt_ready <= 1'b0;
    end else if (!en_filter) begin
      // filt_data deliberately keeps the last average.
      state      <= IDLE;
      sum        <= '0;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      filt_valid <= 1'b0;
      filt_ready <= 1'b0;
    end else begin
      filt_valid <= out_fire;
      if (state == IDLE)
        state <= FILL;
      if (accept) begin
        sum    <= sum_nxt;
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (state == FILL)
          fill_cnt <= fill_cnt + FW'(1);
      end
      if (out_fire) begin
        filt_data  <= avg_nxt;
        filt_ready <= 1'b1;
        state      <= RUN;
      end
    end
  end

  // Window storage has no reset; FILL writes every entry before RUN reads it.
  always_ff @(posedge clk) begin
    if (rst_n && accept)
      win_mem[wr_ptr] <= sample_data;
  end

`ifdef SAMPLE_MAVG_PEAK_EN
  localparam logic signed [12:0] PEAK_MIN = 13'h1000;

  always_ff @(posedge clk) begin
    if (!rst_n || !en_filter)
      peak_data <= PEAK_MIN;
    else if (out_fire && (peak_clr || (avg_nxt > peak_data)))
      peak_data <= avg_nxt;
    else if (peak_clr)
      peak_data <= PEAK_MIN;
  end
`endif

endmodule

// File: tb/tb_sample_mavg_filter.sv
// Scoreboard bench for sample_mavg_filter (DEPTH_LOG2=4): a window model pushes
// expected averages, a monitor pops them on every filt_valid.
module tb_sample_mavg_filter;
  localparam int N = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en_filter;
  logic               sample_valid;
  logic signed [12:0] sample_data;
  logic signed [12:0] filt_data;
  logic               filt_valid;
  logic               filt_ready;
`ifdef SAMPLE_MAVG_PEAK_EN
  logic               peak_clr;
  logic signed [12:0] peak_data;
  int                 m_peak;
`endif

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int win[$];
  bit m_on = 1'b0;

  always #5 clk = ~clk;

  sample_mavg_filter #(.DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_filter    (en_filter),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
`ifdef SAMPLE_MAVG_PEAK_EN
    .peak_clr     (peak_clr),
    .peak_data    (peak_data),
`endif
    .filt_data    (filt_data),
    .filt_valid   (filt_valid),
    .filt_ready   (filt_ready)
  );

  function automatic int floor_avg(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  // Monitor: every filt_valid must match the oldest expected average.
  always begin
    @(posedge clk);
    #1;
    if (filt_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_filt_valid: got data=%0d, required no output", filt_data);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (filt_data !== 13'(e)) begin
          errors++;
          $display("FAIL filt_data: got %0d, required %0d", filt_data, e);
        end
      end
    end
  end

  // Drives one sample for one cycle (caller sits at a negedge) and updates the model.
  task automatic drive(input int d);
    sample_valid = 1'b1;
    sample_data  = 13'(d);
    if (en_filter && m_on) begin
      int s;
      win.push_back(d);
      if (win.size() > N) void'(win.pop_front());
      if (win.size() == N) begin
        s = 0;
        foreach (win[i]) s += win[i];
        exp_q.push_back(floor_avg(s));
`ifdef SAMPLE_MAVG_PEAK_EN
        if (peak_clr || floor_avg(s) > m_peak) m_peak = floor_avg(s);
      end else if (peak_clr) begin
        m_peak = -4096;
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input int d);
    drive(d);
    sample_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic enable_filter();
    en_filter = 1'b1;
    @(negedge clk);
    m_on = 1'b1;
    win.delete();
  endtask

  task automatic disable_filter();
    en_filter = 1'b0;
    @(negedge clk);
    m_on = 1'b0;
    win.delete();
`ifdef SAMPLE_MAVG_PEAK_EN
    m_peak = -4096;
`endif
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_outputs: got %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 3;
    if (filt_data !== 13'sd0) begin errors++; $display("FAIL reset_data: got %0d, required 0", filt_data); end
    if (filt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", filt_valid); end
    if (filt_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", filt_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_run();
    enable_filter();
    for (int i = 1; i <= N; i++) begin
      send(100);
      if (i == N - 1) begin
        checks++;
        if (filt_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_early: got %b, required 0", filt_ready); end
      end
    end
    checks += 2;
    if (filt_ready !== 1'b1) begin errors++; $display("FAIL fill_ready: got %b, required 1", filt_ready); end
    if (filt_data !== 13'sd100) begin errors++; $display("FAIL fill_first_avg: got %0d, required 100", filt_data); end
    send(1700);
    checks++;
    if (filt_data !== 13'sd200) begin errors++; $display("FAIL run_step_avg: got %0d, required 200", filt_data); end
    drain("fill_run");
  endtask

  task automatic test_extremes();
    for (int i = 0; i < N; i++) drive(-1);
    sample_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (filt_data !== -13'sd1) begin errors++; $display("FAIL all_minus1: got %0d, required -1", filt_data); end
    for (int i = 0; i < N; i++) drive((i % 2 == 0) ? 4095 : -4096);
    sample_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (filt_data !== -13'sd1) begin errors++; $display("FAIL alternating_extremes: got %0d, required -1", filt_data); end
    drain("extremes");
  endtask

  task automatic test_disable_mid_run();
    logic signed [12:0] last;
    last = filt_data;
    en_filter = 1'b0;
    drive(500);
    sample_valid = 1'b0;
    m_on = 1'b0;
    win.delete();
    checks += 2;
    if (filt_ready !== 1'b0) begin errors++; $display("FAIL disable_ready: got %b, required 0", filt_ready); end
    if (filt_data !== last) begin errors++; $display("FAIL disable_hold: got %0d, required %0d", filt_data, last); end
    enable_filter();
    for (int i = 0; i < N - 1; i++) send(i * 10);
    checks++;
    if (filt_ready !== 1'b0) begin errors++; $display("FAIL refill_ready_early: got %b, required 0", filt_ready); end
    send(-300);
    checks++;
    if (filt_ready !== 1'b1) begin errors++; $display("FAIL refill_ready: got %b, required 1", filt_ready); end
    drain("disable");
  endtask

  task automatic test_reset_mid_fill();
    disable_filter();
    enable_filter();
    for (int i = 0; i < 7; i++) send(-250);
    rst_n = 1'b0;
    en_filter = 1'b0;
    @(negedge clk);
    m_on = 1'b0;
    win.delete();
    checks += 3;
    if (filt_data !== 13'sd0) begin errors++; $display("FAIL midfill_reset_data: got %0d, required 0", filt_data); end
    if (filt_valid !== 1'b0) begin errors++; $display("FAIL midfill_reset_valid: got %b, required 0", filt_valid); end
    if (filt_ready !== 1'b0) begin errors++; $display("FAIL midfill_reset_ready: got %b, required 0", filt_ready); end
    rst_n = 1'b1;
    send(77);
    // Sample arrives in the same cycle the filter is enabled: still IDLE, so dropped.
    en_filter = 1'b1;
    drive(33);
    sample_valid = 1'b0;
    m_on = 1'b1;
    for (int i = 0; i < N - 1; i++) send(40);
    checks++;
    if (filt_ready !== 1'b0) begin errors++; $display("FAIL idle_sample_counted: ready=%b, required 0", filt_ready); end
    send(56);
    drain("reset_mid_fill");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) drive(int'($urandom_range(0, 8191)) - 4096);
    sample_valid = 1'b0;
    drain("back_to_back");
  endtask

`ifdef SAMPLE_MAVG_PEAK_EN
  task automatic test_peak();
    disable_filter();
    enable_filter();
    for (int i = 0; i < N; i++) send(50);
    send(4050);
    send(-2830);
    checks++;
    if (peak_data !== 13'sd300) begin errors++; $display("FAIL peak_max: got %0d, required 300", peak_data); end
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    m_peak = -4096;
    checks++;
    if (peak_data !== -13'sd4096) begin errors++; $display("FAIL peak_clear: got %0d, required -4096", peak_data); end
    send(-590);
    checks += 2;
    if (peak_data !== 13'sd80) begin errors++; $display("FAIL peak_after_clear: got %0d, required 80", peak_data); end
    if (peak_data !== 13'(m_peak)) begin errors++; $display("FAIL peak_model: got %0d, required %0d", peak_data, m_peak); end
    drain("peak");
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    en_filter    = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
`ifdef SAMPLE_MAVG_PEAK_EN
    peak_clr     = 1'b0;
    m_peak       = -4096;
`endif
    @(negedge clk);
    test_reset();
    test_fill_run();
    test_extremes();
    test_disable_mid_run();
    test_reset_mid_fill();
    test_back_to_back();
`ifdef SAMPLE_MAVG_PEAK_EN
    test_peak();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
